// File: rtl/reg_addr_sequencer.sv
// Register-address sequencer: presents one or all ADDR_TABLE entries to a bus
// controller with a req/ack handshake, optionally sweeping from a start index with wrap.
module reg_addr_sequencer #(
  parameter int ADDR_W = 7,
  parameter int SEL_W  = 2,
  parameter logic [(2**SEL_W)*ADDR_W-1:0] ADDR_TABLE =
    {7'b1001010, 7'b1000001, 7'b1000101, 7'b0000000}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [SEL_W-1:0]  selec,
  input  logic              ack,
  input  logic              abort,
  output logic [ADDR_W-1:0] direc,
  output logic              req,
  output logic [SEL_W-1:0]  index,
  output logic              busy,
  output logic              done
);
  localparam int N = 2**SEL_W;
  localparam logic [SEL_W:0] N_CNT = (SEL_W+1)'(N);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_NEXT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] direc_q, direc_d;
  logic [SEL_W-1:0]  index_q, index_d;
  logic [SEL_W:0]    cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    direc_d = direc_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: if (start) begin
        index_d = selec;
        mode_d  = mode;
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (abort) state_d = S_IDLE;
        else begin
          direc_d = ADDR_TABLE[index_q*ADDR_W +: ADDR_W];
          state_d = S_REQ;
        end
      end
      // abort outranks ack, so an aborted handshake is never counted
      S_REQ: begin
        if (abort) state_d = S_IDLE;
        else if (ack) begin
          cnt_d   = cnt_q + (SEL_W+1)'(1);
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (abort) state_d = S_IDLE;
        else if (!mode_q) state_d = S_DONE;
        else if (cnt_q < N_CNT) begin
          index_d = index_q + SEL_W'(1);
          state_d = S_LOAD;
        end else state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // status flags are registered from the next state so they line up with it
    req_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      direc_q <= '0;
      index_q <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      direc_q <= direc_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign direc = direc_q;
  assign req   = req_q;
  assign index = index_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule
